next_line_prefetcher: RTL and testbench

NEXT_LINE_PREFETCHER -- requirements
Module: next_line_prefetcher

---
 rtl/next_line_prefetcher_if.sv | 30 +++
 rtl/next_line_prefetcher.sv | 90 +++++++++
 tb/tb_next_line_prefetcher.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/next_line_prefetcher_if.sv
// Bundle between the next-line prefetcher, the cache that triggers it and
// the memory arbiter that serves its line reads.
interface next_line_prefetcher_if #(
    parameter int s_line = 256
);
    logic              trigger_valid;
    logic [31:0]       trigger_address;
    logic              pf_ack;
    logic              prefetch_ready;
    logic [s_line-1:0] prefetch_rdata;
    logic [31:0]       pf_cline_address;
    logic              pf_pmem_read;
    logic [31:0]       pf_pmem_address;
    logic [s_line-1:0] pf_pmem_rdata;
    logic              pf_pmem_resp;

    modport master (
        output trigger_valid, trigger_address, pf_ack,
        output pf_pmem_rdata, pf_pmem_resp,
        input  prefetch_ready, prefetch_rdata, pf_cline_address,
        input  pf_pmem_read, pf_pmem_address
    );

    modport slave (
        input  trigger_valid, trigger_address, pf_ack,
        input  pf_pmem_rdata, pf_pmem_resp,
        output prefetch_ready, prefetch_rdata, pf_cline_address,
        output pf_pmem_read, pf_pmem_address
    );
endinterface

// File: rtl/next_line_prefetcher.sv
// Next-line prefetcher: on a demand-miss fill, fetch the following line
// into a one-line buffer and offer it to the cache until acknowledged.
module next_line_prefetcher #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    next_line_prefetcher_if.slave  bus,
    output logic [15:0]            pf_issued_count,
    output logic [15:0]            pf_dropped_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [31:0]       next_addr;
    logic [31:0]       cline;
    logic [s_line-1:0] rdata;
    logic              issue;
    logic              drop;
    logic              load;

    // Shifting back left discards the carry, giving the modulo-2**32 wrap.
    assign next_addr = ((bus.trigger_address >> s_offset) + 32'd1) << s_offset;

    assign issue = bus.trigger_valid &&
                   ((state == IDLE) ||
                    ((state == READY) && (next_addr != cline)));
    assign drop  = bus.trigger_valid && (state == FETCH);
    assign load  = bus.pf_pmem_resp && (state == FETCH);

    assign bus.pf_pmem_read     = (state == FETCH);
    assign bus.pf_pmem_address  = cline;
    assign bus.pf_cline_address = cline;
    assign bus.prefetch_ready   = (state == READY);
    assign bus.prefetch_rdata   = rdata;

    // Next-state selection; a new line in READY wins over a same-cycle ack.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (issue) state_nx = FETCH;
            end
            FETCH: begin
                if (load) state_nx = READY;
            end
            READY: begin
                if (issue)           state_nx = FETCH;
                else if (bus.pf_ack && !bus.trigger_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Target line address, captured whenever a new read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cline <= '0;
        else if (issue) cline <= next_addr;
    end

    // Line buffer, written only by the response to the in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      rdata <= '0;
        else if (load) rdata <= bus.pf_pmem_rdata;
    end

    // Saturating count of memory reads issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pf_issued_count <= '0;
        else if (issue && (pf_issued_count != 16'hFFFF))
            pf_issued_count <= pf_issued_count + 16'd1;
    end

    // Saturating count of triggers ignored while a read is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pf_dropped_count <= '0;
        else if (drop && (pf_dropped_count != 16'hFFFF))
            pf_dropped_count <= pf_dropped_count + 16'd1;
    end
endmodule

// File: tb/tb_next_line_prefetcher.sv
// Self-checking bench for next_line_prefetcher: vector table plus
// hand-written corner sequences, with a queue of expected buffered lines.
module tb_next_line_prefetcher;
    logic        clk;
    logic        rst;
    logic [15:0] ic;
    logic [15:0] dc;

    next_line_prefetcher_if #(.s_line(256)) bus ();

    next_line_prefetcher #(.s_offset(5), .s_line(256)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .pf_issued_count  (ic),
        .pf_dropped_count (dc)
    );

    typedef struct {
        logic [31:0]  trig;
        int           lat;
        logic [255:0] data;
        logic [31:0]  exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
    } exp_t;

    vec_t vt[4];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive a one-cycle trigger that must start a fetch of exp_addr.
    task automatic issue(logic [31:0] a, logic [31:0] exp_addr,
                         logic [255:0] d);
        exp_t e;
        bus.trigger_valid   = 1'b1;
        bus.trigger_address = a;
        e.addr = exp_addr;
        e.data = d;
        sbq.push_back(e);
        tick();
        bus.trigger_valid = 1'b0;
        chk("issue_read", bus.pf_pmem_read, 1'b1);
        chk("issue_addr", bus.pf_pmem_address, exp_addr);
    endtask

    // Return a line from memory, wait for READY and score the buffer.
    task automatic respond(logic [255:0] d);
        exp_t e;
        int   n;
        bus.pf_pmem_rdata = d;
        bus.pf_pmem_resp  = 1'b1;
        tick();
        bus.pf_pmem_resp  = 1'b0;
        bus.pf_pmem_rdata = {8{32'hDEADBEEF}};
        n = 0;
        while (!bus.prefetch_ready && n < 8) begin
            tick();
            n++;
        end
        if (!bus.prefetch_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got 0 want 1");
        end
        chk("resp_read_drop", bus.pf_pmem_read, 1'b0);
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got line with no expectation");
        end else begin
            e = sbq.pop_front();
            chk("sb_cline", bus.pf_cline_address, e.addr);
            chk("sb_rdata", bus.prefetch_rdata, e.data);
        end
    endtask

    task automatic ack();
        bus.pf_ack = 1'b1;
        tick();
        bus.pf_ack = 1'b0;
        chk("ack_idle", bus.prefetch_ready, 1'b0);
        chk("ack_noread", bus.pf_pmem_read, 1'b0);
    endtask

    initial begin
        logic [15:0] ic0;
        logic [255:0] dold;

        vt[0] = '{32'h0000_1040, 3, {8{32'h1111_0000}}, 32'h0000_1060};
        vt[1] = '{32'hFFFF_FFE0, 1, {8{32'h2222_0001}}, 32'h0000_0000};
        vt[2] = '{32'h0000_001F, 2, {8{32'h3333_0002}}, 32'h0000_0020};
        vt[3] = '{32'h7FFF_FFE5, 4, {8{32'h4444_0003}}, 32'h8000_0000};

        rst = 1'b0;
        bus.trigger_valid   = 1'b0;
        bus.trigger_address = '0;
        bus.pf_ack          = 1'b0;
        bus.pf_pmem_resp    = 1'b0;
        bus.pf_pmem_rdata   = '0;
        #2;
        chk("rst_read", bus.pf_pmem_read, 1'b0);
        chk("rst_ready", bus.prefetch_ready, 1'b0);
        chk("rst_addr", bus.pf_pmem_address, 32'h0);
        chk("rst_cline", bus.pf_cline_address, 32'h0);
        chk("rst_rdata", bus.prefetch_rdata, 256'h0);
        chk("rst_ic", ic, 16'h0);
        chk("rst_dc", dc, 16'h0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            issue(vt[i].trig, vt[i].exp_addr, vt[i].data);
            for (int k = 1; k < vt[i].lat; k++) begin
                tick();
                chk("hold_read", bus.pf_pmem_read, 1'b1);
                chk("hold_addr", bus.pf_pmem_address, vt[i].exp_addr);
            end
            respond(vt[i].data);
            ack();
            chk("vec_ic", ic, 16'(i + 1));
        end

        dold = bus.prefetch_rdata;
        bus.pf_pmem_rdata = {8{32'h5555_AAAA}};
        bus.pf_pmem_resp  = 1'b1;
        bus.pf_ack        = 1'b1;
        tick();
        bus.pf_pmem_resp  = 1'b0;
        bus.pf_ack        = 1'b0;
        chk("idle_resp_ready", bus.prefetch_ready, 1'b0);
        chk("idle_resp_rdata", bus.prefetch_rdata, dold);

        issue(32'h0000_1040, 32'h0000_1060, {8{32'h6666_0004}});
        bus.trigger_valid   = 1'b1;
        bus.trigger_address = 32'h0000_2000;
        bus.pf_ack          = 1'b1;
        tick();
        bus.trigger_valid = 1'b0;
        bus.pf_ack        = 1'b0;
        chk("drop_addr", bus.pf_pmem_address, 32'h0000_1060);
        chk("drop_read", bus.pf_pmem_read, 1'b1);
        chk("drop_dc", dc, 16'd1);
        chk("drop_ic", ic, 16'd5);
        respond({8{32'h6666_0004}});

        bus.trigger_valid   = 1'b1;
        bus.trigger_address = 32'h0000_1040;
        tick();
        bus.trigger_valid = 1'b0;
        chk("same_ready", bus.prefetch_ready, 1'b1);
        chk("same_cline", bus.pf_cline_address, 32'h0000_1060);
        chk("same_ic", ic, 16'd5);
        chk("same_dc", dc, 16'd1);
        ic0 = ic;
        issue(32'h0000_3000, 32'h0000_3020, {8{32'h7777_0005}});
        chk("new_ready", bus.prefetch_ready, 1'b0);
        chk("new_ic", ic, ic0 + 16'd1);
        respond({8{32'h7777_0005}});

        bus.pf_ack = 1'b1;
        issue(32'h0000_4000, 32'h0000_4020, {8{32'h8888_0006}});
        bus.pf_ack = 1'b0;
        respond({8{32'h8888_0006}});
        ack();

        issue(32'h0000_5000, 32'h0000_5020, {8{32'h9999_0007}});
        #2;
        rst = 1'b0;
        #1;
        chk("arst_read", bus.pf_pmem_read, 1'b0);
        chk("arst_addr", bus.pf_pmem_address, 32'h0);
        chk("arst_ready", bus.prefetch_ready, 1'b0);
        chk("arst_rdata", bus.prefetch_rdata, 256'h0);
        chk("arst_ic", ic, 16'h0);
        chk("arst_dc", dc, 16'h0);
        sbq.delete();
        tick();
        rst = 1'b1;
        bus.pf_pmem_rdata = {8{32'h9999_0007}};
        bus.pf_pmem_resp  = 1'b1;
        tick();
        bus.pf_pmem_resp  = 1'b0;
        chk("stale_ready", bus.prefetch_ready, 1'b0);
        chk("stale_read", bus.pf_pmem_read, 1'b0);
        chk("stale_rdata", bus.prefetch_rdata, 256'h0);

        issue(32'h0000_6000, 32'h0000_6020, {8{32'hABCD_0008}});
        bus.trigger_valid   = 1'b1;
        bus.trigger_address = 32'h0000_7000;
        for (int k = 0; k < 65536; k++) @(posedge clk);
        #1;
        chk("sat_dc", dc, 16'hFFFF);
        tick();
        bus.trigger_valid = 1'b0;
        chk("sat_hold", dc, 16'hFFFF);
        chk("sat_addr", bus.pf_pmem_address, 32'h0000_6020);
        chk("sat_ic", ic, 16'd1);
        respond({8{32'hABCD_0008}});
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
